// File: rtl/apb_timer_pkg.sv
// Shared timer/bridge constants: slave window bases, timer register offsets,
// CTRL/STATUS bit positions and the register-offset decoder.
package apb_timer_pkg;

  localparam logic [31:0] APB_PSEL0_BASE = 32'h0000_0000;
  localparam logic [31:0] APB_PSEL1_BASE = 32'h0000_0100;
  localparam logic [31:0] APB_PSEL1_LAST = 32'h0000_01FF;

  localparam logic [7:0] TMR_CTRL   = 8'h00;
  localparam logic [7:0] TMR_PRESC  = 8'h04;
  localparam logic [7:0] TMR_LOAD   = 8'h08;
  localparam logic [7:0] TMR_COUNT  = 8'h0C;
  localparam logic [7:0] TMR_STATUS = 8'h10;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_RELOAD_BIT = 1;
  localparam int CTRL_IRQEN_BIT  = 2;
  localparam int STATUS_EXP_BIT  = 0;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_PRESC,
    REG_LOAD,
    REG_COUNT,
    REG_STATUS,
    REG_NONE
  } tmr_reg_e;

  // Full byte-offset compare: unaligned or unmapped offsets decode to REG_NONE.
  function automatic tmr_reg_e tmr_decode(input logic [7:0] addr);
    tmr_reg_e r;
    case (addr)
      TMR_CTRL:   r = REG_CTRL;
      TMR_PRESC:  r = REG_PRESC;
      TMR_LOAD:   r = REG_LOAD;
      TMR_COUNT:  r = REG_COUNT;
      TMR_STATUS: r = REG_STATUS;
      default:    r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB slave-side signal bundle between the bridge (master) and the timer (slave).
interface apb_timer_if;
  logic        PSEL;
  logic        Pen;
  logic        Pwrite;
  logic [7:0]  Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;

  modport master (output PSEL, Pen, Pwrite, Paddr, Pwdata, input Prdata);
  modport slave  (input PSEL, Pen, Pwrite, Paddr, Pwdata, output Prdata);
endinterface

// File: rtl/apb_timer_presc.sv
// Prescaler: counts 0..presc while enabled and emits a one-cycle tick on the
// terminal count. A clear (LOAD write) restarts the count and swallows the tick.
module apb_timer_presc #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               hit;

  assign hit    = (pcnt_q == presc_i);
  assign tick_o = en_i & hit & ~clr_i;

  // Next count: wrap on terminal count, hold at zero while disabled or cleared.
  always_comb begin
    pcnt_d = pcnt_q + PRESC_W'(1);
    if (clr_i || !en_i || hit) pcnt_d = '0;
  end

  // Prescaler count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/apb_timer.sv
// APB timer slave: register file, read mux and prescaled down-counter with
// auto-reload / one-shot modes and a sticky expiry flag.
// Optional feature macro: APB_TIMER_IRQ_EN (adds CTRL.IRQEN and a registered irq).
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic         PCLK,
  input  logic         Prst,
  apb_timer_if.slave   bus,
  output logic         irq
);

  tmr_reg_e           sel;
  logic               wr_en, wr_ctrl, wr_presc, wr_load, wr_status;
  logic               tick;

  logic               en_q, en_d;
  logic               reload_q, reload_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               exp_q, exp_d;
  logic               irqen_q;
  logic [31:0]        rdata;

  assign sel       = tmr_decode(bus.Paddr);
  assign wr_en     = bus.PSEL & bus.Pen & bus.Pwrite;
  assign wr_ctrl   = wr_en & (sel == REG_CTRL);
  assign wr_presc  = wr_en & (sel == REG_PRESC);
  assign wr_load   = wr_en & (sel == REG_LOAD);
  assign wr_status = wr_en & (sel == REG_STATUS);

  apb_timer_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk_i   (PCLK),
    .rst_ni  (Prst),
    .en_i    (en_q),
    .clr_i   (wr_load),
    .presc_i (presc_q),
    .tick_o  (tick)
  );

  // Next-state: later assignments win, giving LOAD write > tick, CTRL write >
  // one-shot EN clear, and expiry set > same-cycle W1C.
  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    load_d   = load_q;
    count_d  = count_q;
    exp_d    = exp_q;

    if (wr_status && bus.Pwdata[STATUS_EXP_BIT]) exp_d = 1'b0;

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        exp_d = 1'b1;
        if (reload_q) count_d = load_q;
        else          en_d    = 1'b0;
      end
    end

    if (wr_ctrl) begin
      en_d     = bus.Pwdata[CTRL_EN_BIT];
      reload_d = bus.Pwdata[CTRL_RELOAD_BIT];
    end
    if (wr_presc) presc_d = bus.Pwdata[PRESC_W-1:0];
    if (wr_load) begin
      load_d  = bus.Pwdata[CNT_W-1:0];
      count_d = bus.Pwdata[CNT_W-1:0];
    end
  end

  // Register file and counter state.
  always_ff @(posedge PCLK or negedge Prst) begin
    if (!Prst) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      presc_q  <= '0;
      load_q   <= '0;
      count_q  <= '0;
      exp_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      load_q   <= load_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
    end
  end

`ifdef APB_TIMER_IRQ_EN
  logic irq_q;

  // IRQEN bit and registered level interrupt (one cycle behind EXP/IRQEN).
  always_ff @(posedge PCLK or negedge Prst) begin
    if (!Prst) begin
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_ctrl) irqen_q <= bus.Pwdata[CTRL_IRQEN_BIT];
      irq_q <= exp_q & irqen_q;
    end
  end

  assign irq = irq_q;
`else
  assign irqen_q = 1'b0;
  assign irq     = 1'b0;
`endif

  // Read mux; unimplemented bits and offsets read as zero.
  always_comb begin
    rdata = '0;
    case (sel)
      REG_CTRL: begin
        rdata[CTRL_EN_BIT]     = en_q;
        rdata[CTRL_RELOAD_BIT] = reload_q;
        rdata[CTRL_IRQEN_BIT]  = irqen_q;
      end
      REG_PRESC:  rdata = 32'(presc_q);
      REG_LOAD:   rdata = 32'(load_q);
      REG_COUNT:  rdata = 32'(count_q);
      REG_STATUS: rdata[STATUS_EXP_BIT] = exp_q;
      default:    rdata = '0;
    endcase
  end

  // Zero when not read-selected so slave read buses can be OR-ed together.
  assign bus.Prdata = (Prst && bus.PSEL && !bus.Pwrite) ? rdata : 32'h0;

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: reads push expected values to a
// scoreboard queue, and the sampled Prdata is popped against them.
module tb_apb_timer;
  import apb_timer_pkg::*;

  logic PCLK;
  logic Prst;
  logic irq;

  apb_timer_if bus_if ();

  apb_timer dut (
    .PCLK (PCLK),
    .Prst (Prst),
    .bus  (bus_if),
    .irq  (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] sb_exp[$];
  string       sb_tag[$];

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic bus_idle();
    bus_if.PSEL   = 1'b0;
    bus_if.Pen    = 1'b0;
    bus_if.Pwrite = 1'b0;
    bus_if.Paddr  = 8'h00;
    bus_if.Pwdata = 32'h0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Setup phase then access phase; the write commits on the second edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_if.PSEL   = 1'b1;
    bus_if.Pen    = 1'b0;
    bus_if.Pwrite = 1'b1;
    bus_if.Paddr  = a;
    bus_if.Pwdata = d;
    @(posedge PCLK);
    #1 bus_if.Pen = 1'b1;
    @(posedge PCLK);
    #1 bus_idle();
  endtask

  // Setup-phase read: Prdata is combinational, so no edge is consumed.
  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] obs;
    sb_exp.push_back(e);
    sb_tag.push_back(tag);
    bus_if.PSEL   = 1'b1;
    bus_if.Pen    = 1'b0;
    bus_if.Pwrite = 1'b0;
    bus_if.Paddr  = a;
    #1 obs = bus_if.Prdata;
    bus_idle();
    chk(sb_tag.pop_front(), obs, sb_exp.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_ar[12];
    int cnt_os[6];
    cnt_ar = '{2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2};
    cnt_os = '{2, 1, 0, 0, 0, 0};

    bus_idle();
    Prst = 1'b0;
    cycles(2);
    rd("rst_hold_ctrl",  TMR_CTRL,  32'h0);
    rd("rst_hold_count", TMR_COUNT, 32'h0);
    chk("rst_hold_irq", irq, 1'b0);
    Prst = 1'b1;
    cycles(1);
    rd("rst_ctrl",   TMR_CTRL,   32'h0);
    rd("rst_presc",  TMR_PRESC,  32'h0);
    rd("rst_load",   TMR_LOAD,   32'h0);
    rd("rst_count",  TMR_COUNT,  32'h0);
    rd("rst_status", TMR_STATUS, 32'h0);
    chk("rst_irq", irq, 1'b0);

    // Register access
    wr(TMR_PRESC, 32'd3);
    wr(TMR_LOAD, 32'h10);
    rd("reg_presc", TMR_PRESC, 32'd3);
    rd("reg_load",  TMR_LOAD,  32'h10);
    rd("reg_count", TMR_COUNT, 32'h10);
    rd("reg_unmapped", 8'h14, 32'h0);
    wr(8'h14, 32'hFFFF_FFFF);
    rd("reg_after_unmapped_ctrl",   TMR_CTRL,   32'h0);
    rd("reg_after_unmapped_presc",  TMR_PRESC,  32'd3);
    rd("reg_after_unmapped_load",   TMR_LOAD,   32'h10);
    rd("reg_after_unmapped_count",  TMR_COUNT,  32'h10);
    rd("reg_after_unmapped_status", TMR_STATUS, 32'h0);
    wr(TMR_PRESC, 32'hFFFF_0007);
    rd("reg_presc_width", TMR_PRESC, 32'd7);
    wr(TMR_CTRL, 32'h6);
`ifdef APB_TIMER_IRQ_EN
    rd("reg_ctrl_bits", TMR_CTRL, 32'h6);
`else
    rd("reg_ctrl_bits", TMR_CTRL, 32'h2);
`endif
    wr(TMR_CTRL, 32'h0);

    // Auto-reload: PRESC=1, LOAD=2
    wr(TMR_PRESC, 32'd1);
    wr(TMR_LOAD, 32'd2);
    wr(TMR_CTRL, 32'h3);
    for (int k = 1; k <= 12; k++) begin
      cycles(1);
      rd($sformatf("ar_count_c%0d", k), TMR_COUNT, 32'(cnt_ar[k-1]));
      rd($sformatf("ar_exp_c%0d", k), TMR_STATUS, (k >= 6) ? 32'h1 : 32'h0);
    end
    wr(TMR_STATUS, 32'h1);
    rd("ar_w1c", TMR_STATUS, 32'h0);
    cycles(3);
    rd("ar_exp_c17", TMR_STATUS, 32'h0);
    cycles(1);
    rd("ar_exp_c18", TMR_STATUS, 32'h1);
    wr(TMR_CTRL, 32'h0);
    wr(TMR_STATUS, 32'h1);
    rd("ar_stop_status", TMR_STATUS, 32'h0);

    // One-shot: PRESC=0, LOAD=3
    wr(TMR_PRESC, 32'd0);
    wr(TMR_LOAD, 32'd3);
    wr(TMR_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      cycles(1);
      rd($sformatf("os_count_c%0d", k), TMR_COUNT, 32'(cnt_os[k-1]));
      rd($sformatf("os_exp_c%0d", k), TMR_STATUS, (k >= 4) ? 32'h1 : 32'h0);
      rd($sformatf("os_ctrl_c%0d", k), TMR_CTRL, (k >= 4) ? 32'h0 : 32'h1);
    end
`ifndef APB_TIMER_IRQ_EN
    chk("os_irq_tied_low", irq, 1'b0);
`endif
    wr(TMR_STATUS, 32'h1);

    // Collision: LOAD write on the tick edge, then a mid-prescale LOAD write
    wr(TMR_PRESC, 32'd3);
    wr(TMR_LOAD, 32'd8);
    wr(TMR_CTRL, 32'h1);
    cycles(6);
    wr(TMR_LOAD, 32'd5);
    rd("col_count", TMR_COUNT, 32'd5);
    rd("col_exp", TMR_STATUS, 32'h0);
    cycles(3);
    rd("col_count_hold", TMR_COUNT, 32'd5);
    cycles(1);
    rd("col_count_dec", TMR_COUNT, 32'd4);
    wr(TMR_LOAD, 32'd9);
    cycles(3);
    rd("pclr_count_hold", TMR_COUNT, 32'd9);
    cycles(1);
    rd("pclr_count_dec", TMR_COUNT, 32'd8);
    wr(TMR_CTRL, 32'h0);

`ifdef APB_TIMER_IRQ_EN
    wr(TMR_STATUS, 32'h1);
    wr(TMR_PRESC, 32'd0);
    wr(TMR_LOAD, 32'd1);
    wr(TMR_CTRL, 32'h5);
    cycles(1);
    rd("irq_count_c1", TMR_COUNT, 32'd0);
    chk("irq_c1", irq, 1'b0);
    cycles(1);
    rd("irq_exp_c2", TMR_STATUS, 32'h1);
    chk("irq_c2", irq, 1'b0);
    cycles(1);
    chk("irq_c3", irq, 1'b1);
    rd("irq_ctrl_oneshot", TMR_CTRL, 32'h4);
    wr(TMR_STATUS, 32'h1);
    rd("irq_w1c_status", TMR_STATUS, 32'h0);
    chk("irq_w1c_lag", irq, 1'b1);
    cycles(1);
    chk("irq_w1c_low", irq, 1'b0);
    wr(TMR_LOAD, 32'd1);
    wr(TMR_CTRL, 32'h7);
    cycles(2);
    wr(TMR_STATUS, 32'h1);
    rd("irq_set_beats_w1c", TMR_STATUS, 32'h1);
    wr(TMR_CTRL, 32'h3);
    chk("irq_irqen_lag", irq, 1'b1);
    cycles(1);
    chk("irq_irqen_low", irq, 1'b0);
    wr(TMR_CTRL, 32'h0);
    wr(TMR_STATUS, 32'h1);
`endif

    // Asynchronous reset mid-operation
    wr(TMR_PRESC, 32'd0);
    wr(TMR_LOAD, 32'd7);
    wr(TMR_CTRL, 32'h3);
    cycles(2);
    Prst = 1'b0;
    rd("mid_rst_prdata", TMR_COUNT, 32'h0);
    chk("mid_rst_irq", irq, 1'b0);
    cycles(1);
    Prst = 1'b1;
    rd("mid_rst_count", TMR_COUNT, 32'h0);
    rd("mid_rst_load",  TMR_LOAD,  32'h0);
    rd("mid_rst_ctrl",  TMR_CTRL,  32'h0);
    cycles(3);
    rd("mid_rst_count_idle", TMR_COUNT, 32'h0);

    chk("sb_empty", 32'(sb_exp.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
